// File: rtl/aib_avmm_arb.sv
// Two-port round-robin arbiter and sequencer for the channel-config AVMM bus.
// Runs one transaction at a time and aborts any transaction that outlives TIMEOUT cycles.
module aib_avmm_arb #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_write,
    input  logic                  m0_read,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]           m0_wdata,
    input  logic [3:0]            m0_byte_en,
    output logic                  m0_waitreq,
    output logic [31:0]           m0_rdata,
    output logic                  m0_rdatavld,
    input  logic                  m1_write,
    input  logic                  m1_read,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_wdata,
    input  logic [3:0]            m1_byte_en,
    output logic                  m1_waitreq,
    output logic [31:0]           m1_rdata,
    output logic                  m1_rdatavld,
    output logic                  avmm_write,
    output logic                  avmm_read,
    output logic [ADDR_WIDTH-1:0] avmm_addr,
    output logic [31:0]           avmm_wdata,
    output logic [3:0]            avmm_byte_en,
    input  logic                  avmm_waitreq,
    input  logic [31:0]           avmm_rdata,
    input  logic                  avmm_rdatavld,
    output logic                  timeout_err,
    output logic                  busy
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} state_t;

    state_t             state;
    logic               rr_ptr;
    logic               cur;
    logic               is_read;
    logic [CNT_W-1:0]   tcnt;
    logic [CNT_W-1:0]   tcnt_inc;
    logic               timed_out;
    logic               req0;
    logic               req1;
    logic               gnt_valid;
    logic               gnt_sel;
    logic               sel_write;
    logic               wr_done;
    logic               rd_ok;
    logic               abort;
    logic               deliver;
    logic [31:0]        rd_data;

    // Grant decode; a requester is only acknowledged while idle and out of reset.
    always_comb begin
        req0      = m0_read | m0_write;
        req1      = m1_read | m1_write;
        gnt_valid = !reset && (state == IDLE) && (req0 || req1);
        gnt_sel   = (req0 && req1) ? rr_ptr : req1;
        sel_write = gnt_sel ? m1_write : m0_write;
    end

    assign m0_waitreq = !(gnt_valid && !gnt_sel);
    assign m1_waitreq = !(gnt_valid && gnt_sel);
    assign busy       = (state != IDLE);

    // Completion beats timeout; a read accepted without data at the limit still aborts.
    always_comb begin
        tcnt_inc  = tcnt + CNT_W'(1);
        timed_out = (tcnt_inc == CNT_W'(TIMEOUT));
        wr_done   = (state == ISSUE) && !is_read && !avmm_waitreq;
        rd_ok     = is_read && avmm_rdatavld &&
                    (((state == ISSUE) && !avmm_waitreq) || (state == RDWAIT));
        abort     = ((state == ISSUE) || (state == RDWAIT)) && timed_out && !wr_done && !rd_ok;
        deliver   = rd_ok || (abort && is_read);
        rd_data   = rd_ok ? avmm_rdata : 32'h0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= 1'b0;
            cur          <= 1'b0;
            is_read      <= 1'b0;
            tcnt         <= '0;
            avmm_write   <= 1'b0;
            avmm_read    <= 1'b0;
            avmm_addr    <= '0;
            avmm_wdata   <= '0;
            avmm_byte_en <= '0;
            m0_rdata     <= '0;
            m1_rdata     <= '0;
            m0_rdatavld  <= 1'b0;
            m1_rdatavld  <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            m0_rdatavld <= 1'b0;
            m1_rdatavld <= 1'b0;
            timeout_err <= abort;
            if ((state == ISSUE) || (state == RDWAIT)) begin
                tcnt <= tcnt_inc;
            end
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        cur          <= gnt_sel;
                        rr_ptr       <= ~gnt_sel;
                        tcnt         <= '0;
                        is_read      <= !sel_write;
                        avmm_write   <= sel_write;
                        avmm_read    <= !sel_write;
                        avmm_addr    <= gnt_sel ? m1_addr : m0_addr;
                        avmm_wdata   <= gnt_sel ? m1_wdata : m0_wdata;
                        avmm_byte_en <= gnt_sel ? m1_byte_en : m0_byte_en;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!avmm_waitreq || abort) begin
                        avmm_write <= 1'b0;
                        avmm_read  <= 1'b0;
                    end
                    if (deliver) begin
                        state <= RESP;
                    end else if (wr_done || abort) begin
                        state <= IDLE;
                    end else if (!avmm_waitreq) begin
                        state <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    if (deliver) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            // Response data lands in the granted port only; the other port keeps its last read.
            if (deliver) begin
                if (cur) begin
                    m1_rdata    <= rd_data;
                    m1_rdatavld <= 1'b1;
                end else begin
                    m0_rdata    <= rd_data;
                    m0_rdatavld <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aib_avmm_arb.sv
// Randomized bench for aib_avmm_arb: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed timing and data expectations.
module tb_aib_avmm_arb;

    localparam int unsigned AW = 17;
    localparam int unsigned TO = 8;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    be;
    } req_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_write, m0_read, m1_write, m1_read;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [31:0]   m0_wdata, m1_wdata;
    logic [3:0]    m0_byte_en, m1_byte_en;
    logic          m0_waitreq, m1_waitreq, m0_rdatavld, m1_rdatavld;
    logic [31:0]   m0_rdata, m1_rdata;
    logic          avmm_write, avmm_read, avmm_waitreq, avmm_rdatavld;
    logic [AW-1:0] avmm_addr;
    logic [31:0]   avmm_wdata, avmm_rdata;
    logic [3:0]    avmm_byte_en;
    logic          timeout_err, busy;

    aib_avmm_arb #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .m0_write(m0_write), .m0_read(m0_read), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_byte_en(m0_byte_en), .m0_waitreq(m0_waitreq), .m0_rdata(m0_rdata), .m0_rdatavld(m0_rdatavld),
        .m1_write(m1_write), .m1_read(m1_read), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_byte_en(m1_byte_en), .m1_waitreq(m1_waitreq), .m1_rdata(m1_rdata), .m1_rdatavld(m1_rdatavld),
        .avmm_write(avmm_write), .avmm_read(avmm_read), .avmm_addr(avmm_addr), .avmm_wdata(avmm_wdata),
        .avmm_byte_en(avmm_byte_en), .avmm_waitreq(avmm_waitreq), .avmm_rdata(avmm_rdata),
        .avmm_rdatavld(avmm_rdatavld), .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    req_t q0[$];
    req_t q1[$];

    // slave behaviour knobs
    int wait_pct, stall, lat_min, lat_max, never_pct, stray_pct, sl_wait;
    bit fix_en;
    logic [31:0] fix_data;
    bit rst_drive;

    // reference model: one transaction record plus per-port read-data registers
    bit          m_busy, m_resp, m_acc, m_rd, m_port, m_rr, m_terr;
    int          m_age;
    logic [AW-1:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic [31:0] m_rdata [2];

    // observations of the DUT for directed scenarios
    int n_wr, n_busy, n_terr, n_vld0, n_vld1, last_g, last_t, last_v0, last_v1, first_wr;
    int glog[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic req_t mk(input logic wr, input logic rd, input logic [AW-1:0] a,
                                input logic [31:0] d, input logic [3:0] be);
        req_t r;
        r.wr = wr; r.rd = rd; r.addr = a; r.data = d; r.be = be;
        return r;
    endfunction

    function automatic req_t rnd_req();
        int k;
        k = int'($urandom_range(3));
        return mk(k != 2, k >= 2, AW'($urandom), $urandom, 4'($urandom));
    endfunction

    task automatic model_reset();
        m_busy = 0; m_resp = 0; m_acc = 0; m_rd = 0; m_port = 0; m_rr = 0; m_terr = 0; m_age = 0;
        m_rdata[0] = '0; m_rdata[1] = '0;
    endtask

    task automatic clear_obs();
        n_wr = 0; n_busy = 0; n_terr = 0; n_vld0 = 0; n_vld1 = 0;
        last_g = -1; last_t = -1; last_v0 = -1; last_v1 = -1; first_wr = -1;
        glog.delete();
    endtask

    task automatic set_slave(input int wp, input int st, input int lmin, input int lmax,
                             input int nv, input int sy, input bit fe, input logic [31:0] fd);
        wait_pct = wp; stall = st; lat_min = lmin; lat_max = lmax;
        never_pct = nv; stray_pct = sy; fix_en = fe; fix_data = fd;
    endtask

    // One clock: drive inputs at negedge, compare against the model, then advance the model.
    task automatic step();
        logic req0, req1, g_ok, g_sel, rdv, wd, rk, in_iss, exp_w, exp_r;
        logic [31:0] rdat;
        int lat;
        req_t src;
        @(negedge clk);
        cyc++;
        reset = rst_drive;
        if (q0.size() > 0) begin
            m0_write = q0[0].wr; m0_read = q0[0].rd; m0_addr = q0[0].addr;
            m0_wdata = q0[0].data; m0_byte_en = q0[0].be;
        end else begin
            m0_write = 0; m0_read = 0; m0_addr = AW'($urandom); m0_wdata = $urandom; m0_byte_en = 4'($urandom);
        end
        if (q1.size() > 0) begin
            m1_write = q1[0].wr; m1_read = q1[0].rd; m1_addr = q1[0].addr;
            m1_wdata = q1[0].data; m1_byte_en = q1[0].be;
        end else begin
            m1_write = 0; m1_read = 0; m1_addr = AW'($urandom); m1_wdata = $urandom; m1_byte_en = 4'($urandom);
        end
        if (reset) model_reset();
        in_iss = m_busy && !m_acc && !reset;
        avmm_waitreq = (in_iss && m_age < stall) ? 1'b1 : ($urandom_range(99) < wait_pct);
        rdv = 0;
        rdat = $urandom;
        if (sl_wait > 0) begin
            sl_wait--;
            if (sl_wait == 0) begin rdv = 1; if (fix_en) rdat = fix_data; end
        end
        if (in_iss && m_rd && !avmm_waitreq && $urandom_range(99) >= never_pct) begin
            lat = int'($urandom_range(lat_max, lat_min));
            if (lat == 0) begin rdv = 1; if (fix_en) rdat = fix_data; end
            else sl_wait = lat;
        end
        if (!rdv && !(m_busy && m_rd) && $urandom_range(99) < stray_pct) rdv = 1;
        avmm_rdatavld = rdv;
        avmm_rdata = rdat;
        #1;
        req0 = m0_read | m0_write;
        req1 = m1_read | m1_write;
        g_ok = !reset && !m_busy && !m_resp && (req0 || req1);
        g_sel = (req0 && req1) ? m_rr : req1;
        exp_w = m_busy && !m_acc && !m_rd;
        exp_r = m_busy && !m_acc && m_rd;
        chk("m0_waitreq", m0_waitreq, !(g_ok && !g_sel));
        chk("m1_waitreq", m1_waitreq, !(g_ok && g_sel));
        chk("avmm_write", avmm_write, exp_w);
        chk("avmm_read", avmm_read, exp_r);
        chk("busy", busy, m_busy || m_resp);
        chk("timeout_err", timeout_err, m_terr);
        chk("m0_rdatavld", m0_rdatavld, m_resp && m_port == 0);
        chk("m1_rdatavld", m1_rdatavld, m_resp && m_port == 1);
        chk("m0_rdata", m0_rdata, m_rdata[0]);
        chk("m1_rdata", m1_rdata, m_rdata[1]);
        if (exp_w || exp_r) begin
            chk("avmm_addr", avmm_addr, m_addr);
            chk("avmm_wdata", avmm_wdata, m_wdata);
            chk("avmm_byte_en", avmm_byte_en, m_be);
        end
        if (!m0_waitreq) begin last_g = cyc; glog.push_back(0); end
        if (!m1_waitreq) begin last_g = cyc; glog.push_back(1); end
        if (avmm_write) begin n_wr++; if (first_wr < 0) first_wr = cyc; end
        if (busy) n_busy++;
        if (timeout_err) begin n_terr++; last_t = cyc; end
        if (m0_rdatavld) begin n_vld0++; last_v0 = cyc; end
        if (m1_rdatavld) begin n_vld1++; last_v1 = cyc; end
        if (reset) begin
            model_reset();
        end else begin
            m_terr = 0;
            if (m_resp) begin
                m_resp = 0;
            end else if (m_busy) begin
                m_age++;
                wd = !m_acc && !m_rd && !avmm_waitreq;
                rk = m_rd && avmm_rdatavld && (m_acc || !avmm_waitreq);
                if (wd) begin
                    m_busy = 0;
                end else if (rk) begin
                    m_rdata[m_port] = avmm_rdata; m_resp = 1; m_busy = 0;
                end else if (m_age == int'(TO)) begin
                    m_terr = 1; m_busy = 0;
                    if (m_rd) begin m_rdata[m_port] = '0; m_resp = 1; end
                end else if (!m_acc && !avmm_waitreq) begin
                    m_acc = 1;
                end
            end else if (g_ok) begin
                src = g_sel ? q1.pop_front() : q0.pop_front();
                m_port = g_sel; m_rr = !g_sel; m_rd = !src.wr;
                m_addr = src.addr; m_wdata = src.data; m_be = src.be;
                m_age = 0; m_acc = 0; m_busy = 1;
            end
        end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_busy || m_resp) && n < bound) begin
            step();
            n++;
        end
        chk("drain_idle", (q0.size() > 0 || q1.size() > 0 || m_busy || m_resp), 0);
        step();
        step();
    endtask

    task automatic do_reset();
        q0.delete(); q1.delete(); sl_wait = 0;
        rst_drive = 1;
        step(); step();
        rst_drive = 0;
        clear_obs();
    endtask

    int exp_seq[6] = '{0, 1, 0, 1, 0, 1};

    initial begin
        reset = 1; rst_drive = 1; sl_wait = 0;
        m0_write = 0; m0_read = 0; m1_write = 0; m1_read = 0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; m0_byte_en = '0; m1_byte_en = '0;
        avmm_waitreq = 0; avmm_rdatavld = 0; avmm_rdata = '0;
        model_reset();
        clear_obs();
        set_slave(0, 0, 0, 0, 0, 0, 0, '0);

        // reset state with both requesters active
        q0.push_back(mk(0, 1, 17'h0_0010, 32'h0, 4'hF));
        q1.push_back(mk(1, 0, 17'h0_0020, 32'h1, 4'hF));
        step(); step();
        chk("rst_m0_waitreq", m0_waitreq, 1);
        chk("rst_avmm_write", avmm_write, 0);
        do_reset();

        // single write, zero-wait slave
        q0.push_back(mk(1, 0, 17'h0_0204, 32'hA5A5_0001, 4'hF));
        drain(50);
        chk("wr_strobe_cycles", n_wr, 1);
        chk("wr_busy_cycles", n_busy, 1);
        chk("wr_cmd_latency", first_wr - last_g, 1);

        // read on port 1 with 3-cycle slave latency
        set_slave(0, 0, 3, 3, 0, 0, 1, 32'h1234_5678);
        clear_obs();
        q1.push_back(mk(0, 1, 17'h0_0300, 32'h0, 4'hF));
        drain(50);
        chk("rd_m1_pulses", n_vld1, 1);
        chk("rd_m0_pulses", n_vld0, 0);
        chk("rd_m1_data", m1_rdata, 32'h1234_5678);
        chk("rd_m0_data", m0_rdata, 32'h0);
        chk("rd_resp_cycle", last_v1 - last_g, 5);

        // contention from reset: grants must alternate starting at port 0
        do_reset();
        set_slave(0, 0, 0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(1, 0, AW'(i), 32'h100 + 32'(i), 4'h3));
            q1.push_back(mk(1, 1, AW'(i + 8), 32'h200 + 32'(i), 4'hC));
        end
        drain(100);
        chk("contention_grants", glog.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < glog.size()) chk("contention_order", glog[i], exp_seq[i]);
        end
        chk("contention_writes", n_wr, 6);

        // read timeout after a good read, then a fresh request is still served
        set_slave(0, 0, 1, 1, 0, 0, 1, 32'hDEAD_BEEF);
        q0.push_back(mk(0, 1, 17'h0_0800, 32'h0, 4'hF));
        drain(50);
        chk("pre_to_rdata", m0_rdata, 32'hDEAD_BEEF);
        set_slave(0, 0, 1, 1, 100, 0, 0, '0);
        clear_obs();
        q0.push_back(mk(0, 1, 17'h1_F800, 32'h0, 4'hF));
        drain(50);
        chk("to_err_pulses", n_terr, 1);
        chk("to_err_cycle", last_t - last_g, 9);
        chk("to_vld_cycle", last_v0, last_t);
        chk("to_rdata_zero", m0_rdata, 32'h0);
        set_slave(0, 0, 0, 0, 0, 0, 0, '0);
        clear_obs();
        q0.push_back(mk(1, 0, 17'h0_0004, 32'h77, 4'hF));
        drain(50);
        chk("post_to_write", n_wr, 1);

        // downstream stall of 5 cycles on a write
        set_slave(0, 5, 0, 0, 0, 0, 0, '0);
        clear_obs();
        q1.push_back(mk(1, 0, 17'h0_1234, 32'hCAFE_F00D, 4'h5));
        drain(50);
        chk("stall_strobe_cycles", n_wr, 6);
        chk("stall_no_timeout", n_terr, 0);

        // reset while waiting for read data; the late response must be ignored
        set_slave(0, 0, 1, 1, 0, 0, 1, 32'h5555_AAAA);
        q0.push_back(mk(0, 1, 17'h0_0044, 32'h0, 4'hF));
        drain(50);
        chk("pre_rst_rdata", m0_rdata, 32'h5555_AAAA);
        set_slave(0, 0, 6, 6, 0, 0, 1, 32'h0BAD_0BAD);
        q0.push_back(mk(0, 1, 17'h0_0048, 32'h0, 4'hF));
        begin
            int n = 0;
            while (!(m_busy && m_acc) && n < 20) begin step(); n++; end
            chk("reach_rdwait", m_busy && m_acc, 1);
        end
        @(posedge clk);
        #2;
        chk("rdwait_busy", busy, 1);
        reset = 1;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_read", avmm_read, 0);
        chk("async_rst_waitreq", m0_waitreq, 1);
        chk("async_rst_rdata", m0_rdata, 32'h0);
        model_reset();
        q0.delete(); q1.delete();
        rst_drive = 1;
        step(); step();
        rst_drive = 0;
        clear_obs();
        for (int i = 0; i < 10; i++) step();
        chk("late_vld_ignored", n_vld0 + n_vld1, 0);

        // randomized traffic
        do_reset();
        set_slave(30, 0, 0, 8, 15, 5, 0, '0);
        for (int i = 0; i < 2500; i++) begin
            if (q0.size() == 0 && $urandom_range(99) < 40) q0.push_back(rnd_req());
            if (q1.size() == 0 && $urandom_range(99) < 40) q1.push_back(rnd_req());
            if ($urandom_range(999) == 0) begin
                rst_drive = 1; q0.delete(); q1.delete();
                step();
                rst_drive = 0;
            end
            step();
        end
        drain(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
